// File: rtl/hub75_scheduler.sv
// hub75_scheduler
//   Row/bit-plane scheduler for a 1/16-scan HUB75 panel driven by binary-coded
//   modulation. For every (row, plane) pair it asks an external shifter to
//   clock out one row of pixel bits. It then blanks the panel, latches the row,
//   and lights it for BASE_TICKS<<plane cycles, scaled by the global brightness.
//   Planes form the inner loop and rows the outer loop. The double buffer flips
//   only at the end of a frame.
//
// Ports
//   pixel_clk    : sole clock, rising edge
//   reset        : synchronous, active-high
//   shift_start  : 1-cycle request to the shifter to clock out one row
//   shift_row    : row being shifted (stable until the shift completes)
//   shift_plane  : bit-plane being shifted (stable until the shift completes)
//   shift_done   : 1-cycle completion pulse from the shifter
//   hub75_addr   : panel row address (changes only in LATCH)
//   hub75_latch  : panel latch strobe
//   hub75_oe     : panel output enable, 1 = blanked
//   brightness   : global dimming, 15 = full on
//   swap_req     : level request to flip the double buffer
//   swap_ack     : 1-cycle pulse when the flip takes effect
//   front_buffer : buffer select for the read side
//   shift_error  : sticky shifter-timeout flag, cleared only by reset
module hub75_scheduler #(
    parameter int unsigned BASE_TICKS    = 8,
    parameter int unsigned SHIFT_TIMEOUT = 255
) (
    input  logic       pixel_clk,
    input  logic       reset,
    output logic       shift_start,
    output logic [3:0] shift_row,
    output logic [1:0] shift_plane,
    input  logic       shift_done,
    output logic [3:0] hub75_addr,
    output logic       hub75_latch,
    output logic       hub75_oe,
    input  logic [3:0] brightness,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       front_buffer,
    output logic       shift_error
);

    // The display counter must hold BASE_TICKS<<3 without overflow.
    localparam int unsigned DW = $clog2(BASE_TICKS * 8 + 1);
    // Wide enough for N * 16, the largest value of N * (brightness + 1).
    localparam int unsigned MW = DW + 5;
    // The wait counter runs from 0 to SHIFT_TIMEOUT-1.
    localparam int unsigned TW = (SHIFT_TIMEOUT > 1) ? $clog2(SHIFT_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        SHIFT_ISSUE,
        SHIFT_WAIT,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t         state, state_next;
    logic [3:0]     row;
    logic [1:0]     plane;
    logic [TW-1:0]  wait_cnt;
    logic [DW-1:0]  disp_cnt;
    logic [3:0]     bright_q;
    logic [DW-1:0]  disp_len;
    logic [MW-1:0]  on_prod;
    logic [DW-1:0]  on_len;
    logic           wait_expired;
    logic           disp_last;
    logic           frame_end;

    always_comb begin
        disp_len     = DW'(BASE_TICKS << plane);
        on_prod      = MW'(disp_len) * (MW'(bright_q) + MW'(1));
        on_len       = DW'(on_prod >> 4);
        wait_expired = (wait_cnt == TW'(SHIFT_TIMEOUT - 1));
        disp_last    = (disp_cnt == disp_len - DW'(1));
        frame_end    = (state == DISPLAY) && disp_last && (row == 4'd15) && (plane == 2'd3);
    end

    always_comb begin
        state_next = state;
        case (state)
            SHIFT_ISSUE: state_next = SHIFT_WAIT;
            SHIFT_WAIT:  if (shift_done || wait_expired) state_next = BLANK;
            BLANK:       state_next = LATCH;
            LATCH:       state_next = DISPLAY;
            DISPLAY:     if (disp_last) state_next = SHIFT_ISSUE;
            default:     state_next = SHIFT_ISSUE;
        endcase
    end

    // Gating shift_start with reset keeps it low while reset holds the FSM
    // in SHIFT_ISSUE. It then fires in the first cycle after reset is released.
    always_comb begin
        shift_start = (state == SHIFT_ISSUE) && !reset;
        hub75_latch = (state == LATCH);
        hub75_oe    = !((state == DISPLAY) && (disp_cnt < on_len));
        shift_row   = row;
        shift_plane = plane;
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state        <= SHIFT_ISSUE;
            row          <= '0;
            plane        <= '0;
            wait_cnt     <= '0;
            disp_cnt     <= '0;
            bright_q     <= '0;
            hub75_addr   <= '0;
            swap_ack     <= 1'b0;
            front_buffer <= 1'b0;
            shift_error  <= 1'b0;
        end else begin
            state    <= state_next;
            swap_ack <= 1'b0;
            case (state)
                SHIFT_ISSUE: wait_cnt <= '0;
                SHIFT_WAIT: begin
                    wait_cnt <= wait_cnt + TW'(1);
                    if (!shift_done && wait_expired) shift_error <= 1'b1;
                end
                // The address is loaded on entry to LATCH, so it changes in the
                // same cycle that the latch strobe is high.
                BLANK: hub75_addr <= row;
                LATCH: begin
                    bright_q <= brightness;
                    disp_cnt <= '0;
                end
                DISPLAY: begin
                    disp_cnt <= disp_cnt + DW'(1);
                    if (disp_last) begin
                        plane <= plane + 2'd1;
                        if (plane == 2'd3) row <= row + 4'd1;
                        if (frame_end && swap_req) begin
                            front_buffer <= !front_buffer;
                            swap_ack     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scheduler.sv
module tb_hub75_scheduler;

    localparam int unsigned BT = 8;

    logic       pixel_clk = 1'b0;
    logic       reset = 1'b1;
    logic       shift_start;
    logic [3:0] shift_row;
    logic [1:0] shift_plane;
    logic       shift_done = 1'b0;
    logic [3:0] hub75_addr;
    logic       hub75_latch;
    logic       hub75_oe;
    logic [3:0] brightness = 4'd15;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic       front_buffer;
    logic       shift_error;

    hub75_scheduler #(.BASE_TICKS(BT), .SHIFT_TIMEOUT(255)) dut (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .shift_start (shift_start),
        .shift_row   (shift_row),
        .shift_plane (shift_plane),
        .shift_done  (shift_done),
        .hub75_addr  (hub75_addr),
        .hub75_latch (hub75_latch),
        .hub75_oe    (hub75_oe),
        .brightness  (brightness),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .front_buffer(front_buffer),
        .shift_error (shift_error)
    );

    always #5 pixel_clk = ~pixel_clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;
    always @(posedge pixel_clk) cyc++;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected behaviour of one (row, plane) window, from its shift_start up
    // to the next shift_start.
    typedef struct {
        int unsigned row;
        int unsigned plane;
        int unsigned len;
        int unsigned on;
        int unsigned fb;
        int unsigned ack;
        int unsigned gap;
    } exp_t;
    exp_t sb[$];

    // Stimulus and reference model. The shifter acks d cycles after the start.
    // Brightness and swap_req are chosen per plane and held for the whole plane.
    bit          drv_en = 0;
    bit          ack_en = 1;
    bit          force_sw = 0;
    int unsigned mrow = 0, mplane = 0, mfb = 0, pend_ack = 0, issued = 0, done_cnt = 0;

    always @(negedge pixel_clk) begin
        int unsigned frame, b, sw, d, n;
        shift_done = 1'b0;
        if (done_cnt != 0) begin
            done_cnt--;
            if (done_cnt == 0) shift_done = 1'b1;
        end
        if (drv_en && shift_start) begin
            frame = issued / 64;
            if (force_sw) begin
                b = 15; sw = 1;
            end else begin
                case (frame)
                    0: begin b = 15; sw = 0; end
                    1: begin
                        b  = (issued % 3 == 0) ? 7 : (issued % 3 == 1) ? 0 : $urandom_range(0, 15);
                        sw = (mrow >= 8) ? 1 : 0;
                    end
                    2: begin b = $urandom_range(0, 15); sw = 1; end
                    default: begin b = $urandom_range(0, 15); sw = $urandom_range(0, 1); end
                endcase
            end
            d = (issued < 64) ? 3 : $urandom_range(1, 5);
            brightness = 4'(b);
            swap_req   = sw[0];
            n = BT << mplane;
            sb.push_back('{mrow, mplane, n, (n * (b + 1)) / 16, mfb, pend_ack, d + 2});
            pend_ack = 0;
            if (mrow == 15 && mplane == 3 && sw == 1) begin
                mfb ^= 1;
                pend_ack = 1;
            end
            if (mplane == 3) begin
                mplane = 0;
                mrow = (mrow + 1) % 16;
            end else begin
                mplane++;
            end
            issued++;
            if (ack_en) done_cnt = d;
        end
    end

    // The monitor observes DUT outputs only. Each window is closed and scored
    // when the next shift_start arrives.
    bit          mon_en = 0;
    bit          in_win = 0;
    bit          after_latch;
    int unsigned w_row, w_plane, w_fb, w_ack, w_latch, w_addr, w_len, w_on;
    int unsigned w_pre_on, w_excl, w_unstable, w_addr_chg, w_start_cyc, w_gap;

    task automatic close_window();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_underflow: window with no expectation queued");
        end else begin
            e = sb.pop_front();
            check("row", w_row, e.row);
            check("plane", w_plane, e.plane);
            check("latch_count", w_latch, 1);
            check("latch_addr", w_addr, e.row);
            check("start_to_latch", w_gap, e.gap);
            check("display_len", w_len, e.len);
            check("oe_low_cycles", w_on, e.on);
            check("oe_low_outside_display", w_pre_on, 0);
            check("latch_oe_overlap", w_excl, 0);
            check("shift_row_plane_stable", w_unstable, 0);
            check("addr_change_outside_latch", w_addr_chg, 0);
            check("front_buffer", w_fb, e.fb);
            check("swap_ack_count", w_ack, e.ack);
        end
    endtask

    always @(negedge pixel_clk) begin
        if (mon_en) begin
            if (hub75_latch && !hub75_oe) w_excl++;
            if (shift_start) begin
                if (in_win) close_window();
                in_win      = 1;
                after_latch = 0;
                w_row       = shift_row;
                w_plane     = shift_plane;
                w_fb        = front_buffer;
                w_ack       = swap_ack;
                w_start_cyc = cyc;
                w_latch = 0; w_addr = 0; w_len = 0; w_on = 0; w_gap = 0;
                w_pre_on = 0; w_excl = 0; w_unstable = 0; w_addr_chg = 0;
            end else if (in_win) begin
                if (swap_ack) w_ack++;
                if (after_latch) begin
                    w_len++;
                    if (!hub75_oe) w_on++;
                    if (hub75_addr != 4'(w_addr)) w_addr_chg++;
                end else begin
                    if (!hub75_oe) w_pre_on++;
                    if (shift_row != 4'(w_row) || shift_plane != 2'(w_plane)) w_unstable++;
                end
                if (hub75_latch) begin
                    w_latch++;
                    w_addr      = hub75_addr;
                    w_gap       = cyc - w_start_cyc;
                    after_latch = 1;
                end
            end
        end
    end

    task automatic reset_model();
        mrow = 0; mplane = 0; mfb = 0; pend_ack = 0; issued = 0; done_cnt = 0;
        sb.delete();
        in_win = 0;
    endtask

    initial begin
        int unsigned t0, err_at, latch_at, latches, err_drop, k;
        bit          found;

        // Reset state
        repeat (3) @(negedge pixel_clk);
        check("rst_oe", hub75_oe, 1);
        check("rst_latch", hub75_latch, 0);
        check("rst_addr", hub75_addr, 0);
        check("rst_front_buffer", front_buffer, 0);
        check("rst_shift_error", shift_error, 0);
        check("rst_shift_start", shift_start, 0);
        check("rst_swap_ack", swap_ack, 0);

        // Randomized frames scored by the scoreboard
        reset_model();
        drv_en = 1;
        mon_en = 1;
        @(posedge pixel_clk); #1 reset = 1'b0;
        @(negedge pixel_clk);
        check("first_shift_start", shift_start, 1);
        check("first_row", shift_row, 0);
        check("first_plane", shift_plane, 0);
        for (int i = 0; i < 40000 && issued < 257; i++) @(negedge pixel_clk);
        check("frames_completed", (issued >= 257) ? 1 : 0, 1);
        @(negedge pixel_clk);
        mon_en = 0;
        drv_en = 0;
        check("scoreboard_drain", sb.size(), 1);

        // Shifter that never acks
        @(posedge pixel_clk); #1 reset = 1'b1;
        ack_en = 0;
        @(posedge pixel_clk); #1;
        reset_model();
        @(posedge pixel_clk); #1 reset = 1'b0;
        t0 = cyc; err_at = 0; latch_at = 0; latches = 0; err_drop = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge pixel_clk);
            k = cyc - t0;
            if (shift_error && err_at == 0) err_at = k;
            if (!shift_error && k >= 256) err_drop++;
            if (hub75_latch) begin
                if (latch_at == 0) latch_at = k;
                latches++;
            end
        end
        check("timeout_error_cycle", err_at, 256);
        check("timeout_latch_cycle", latch_at, 257);
        check("timeout_latches_continue", latches, 5);
        check("shift_error_sticky", err_drop, 0);
        @(posedge pixel_clk); #1 reset = 1'b1;
        @(posedge pixel_clk); #1;
        check("shift_error_reset", shift_error, 0);

        // Reset during DISPLAY of row 5, after the buffer has flipped once
        reset_model();
        ack_en = 1;
        force_sw = 1;
        drv_en = 1;
        @(posedge pixel_clk); #1 reset = 1'b0;
        found = 0;
        for (int i = 0; i < 10000 && !found; i++) begin
            @(negedge pixel_clk);
            if (hub75_latch && hub75_addr == 4'd5 && front_buffer) found = 1;
        end
        check("row5_reached", found, 1);
        repeat (3) @(negedge pixel_clk);
        check("pre_reset_front_buffer", front_buffer, 1);
        drv_en = 0;
        ack_en = 0;
        done_cnt = 0;
        @(posedge pixel_clk); #1 reset = 1'b1;
        @(posedge pixel_clk); #1 reset = 1'b0;
        @(negedge pixel_clk);
        check("midrst_oe", hub75_oe, 1);
        check("midrst_addr", hub75_addr, 0);
        check("midrst_front_buffer", front_buffer, 0);
        check("midrst_shift_start", shift_start, 1);
        check("midrst_row", shift_row, 0);
        check("midrst_plane", shift_plane, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hub75_scheduler.md
HUB75_SCHEDULER -- requirements
Module: hub75_scheduler

Interface
REQ-001 SHALL have parameter BASE_TICKS, default 8: display cycles for bit-plane 0; plane p displays BASE_TICKS<<p cycles.
REQ-002 SHALL have parameter SHIFT_TIMEOUT, default 255: maximum cycles to wait for shift_done.
REQ-003 SHALL have port pixel_clk, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port shift_start, output, 1: one-cycle pulse requesting the shifter to clock out one row.
REQ-006 SHALL have port shift_row, output, 4: row index for the current shift.
REQ-007 SHALL have port shift_plane, output, 2: bit-plane (intensity bit) for the current shift.
REQ-008 SHALL have port shift_done, input, 1: one-cycle pulse from the shifter after 64 pixels are clocked.
REQ-009 SHALL have port hub75_addr, output, 4: panel row address.
REQ-010 SHALL have port hub75_latch, output, 1: panel latch.
REQ-011 SHALL have port hub75_oe, output, 1: panel output enable; 1 = blanked.
REQ-012 SHALL have port brightness, input, 4: global dimming; 15 = full.
REQ-013 SHALL have port swap_req, input, 1: level request to flip the double buffer.
REQ-014 SHALL have port swap_ack, output, 1: one-cycle pulse when the flip takes effect.
REQ-015 SHALL have port front_buffer, output, 1: buffer select driven to the read side.
REQ-016 SHALL have port shift_error, output, 1: sticky shift-timeout flag.

Function
REQ-017 SHALL sequence states SHIFT_ISSUE -> SHIFT_WAIT -> BLANK -> LATCH -> DISPLAY -> (next) SHIFT_ISSUE.
REQ-018 SHALL, in SHIFT_ISSUE, pulse shift_start for exactly 1 cycle with shift_row/shift_plane stable from that cycle until shift_done is received.
REQ-019 SHALL, in SHIFT_WAIT, advance to BLANK on the cycle after shift_done=1; shift_done outside SHIFT_WAIT SHALL be ignored.
REQ-020 SHALL, on SHIFT_TIMEOUT cycles in SHIFT_WAIT without shift_done, set shift_error and proceed to BLANK; shift_error SHALL be cleared only by reset.
REQ-021 SHALL, in BLANK, hold hub75_oe=1 for 1 cycle.
REQ-022 SHALL, in LATCH, assert hub75_latch=1 for 1 cycle, load hub75_addr with shift_row, and keep hub75_oe=1.
REQ-023 SHALL, in DISPLAY, count N = BASE_TICKS<<plane cycles using a counter wide enough for BASE_TICKS<<3 without overflow.
REQ-024 SHALL drive hub75_oe=0 during DISPLAY for the first M = (N*(brightness+1))>>4 cycles and hub75_oe=1 for the remainder.
REQ-025 SHALL sample brightness on DISPLAY entry and hold it for that plane; M=0 SHALL keep oe=1 for the whole plane.
REQ-026 SHALL iterate with plane as the inner loop (0..3) and row as the outer loop (0..15); after row 15, plane 3, the row and plane SHALL wrap to 0.
REQ-027 SHALL treat the last cycle of DISPLAY for row 15, plane 3 as end of frame.
REQ-028 SHALL, at end of frame with swap_req=1, toggle front_buffer and pulse swap_ack for 1 cycle.
REQ-029 SHALL ignore swap_req at all other times; a swap_req held across multiple frames SHALL flip once per frame.
REQ-030 SHALL change front_buffer only at end of frame, never mid-frame.
REQ-031 SHALL make hub75_latch and hub75_oe=0 mutually exclusive.
REQ-032 SHALL keep hub75_addr constant except in LATCH.

Reset
REQ-033 SHALL, with reset=1 at a clock edge, set: state=SHIFT_ISSUE, row=0, plane=0, shift_start=0, hub75_oe=1, hub75_latch=0, hub75_addr=0, swap_ack=0, front_buffer=0, shift_error=0, counters=0.
REQ-034 SHALL, after reset mid-operation, clear any pending shift wait and restart the frame at row 0, plane 0.
REQ-035 SHALL assert the first shift_start on the first cycle after reset deasserts.

Verification
REQ-036 SHALL verify: reset release, shifter model acks 3 cycles after each start -> first shift_start in cycle 1 with row 0, plane 0; latch 1 cycle after BLANK; oe low for 8 cycles with BASE_TICKS=8 and brightness=15.
REQ-037 SHALL verify: full frame at brightness=15 -> 64 shift_start pulses, row/plane order as per REQ-026, oe-low cycles per row 8+16+32+64=120, wrap to row 0, plane 0.
REQ-038 SHALL verify: brightness=7 -> plane 3 oe low for 32 of 64 cycles; brightness=0 -> plane 0 oe low for 0 cycles, plane 3 for 4 cycles.
REQ-039 SHALL verify: swap_req raised mid-frame -> no flip until end of frame, then front_buffer 0->1 with a single-cycle swap_ack; swap_req held -> flips again at the next frame end.
REQ-040 SHALL verify: shifter never acks -> shift_error=1 after 255 cycles; sequencing continues to BLANK/LATCH; shift_error stays set until reset.
REQ-041 SHALL verify: reset asserted during DISPLAY of row 5 -> next cycle oe=1, addr=0, front_buffer=0; restart at row 0, plane 0.
